// File: rtl/gamecntl_sequencer_if.sv
// Coin/start inputs and game-flow outputs of the sequencer.
// master drives the player inputs, slave is the sequencer.
interface gamecntl_sequencer_if;
  logic       coin_n;
  logic       start_n;
  logic [3:0] playtime;
  logic [3:0] credits;
  logic       game_on;
  logic       attract;
  logic       trg_time_n;
  logic [7:0] time_left;
  logic       tick;
  logic       time_up;

  modport master (
    output coin_n,
    output start_n,
    output playtime,
    input  credits,
    input  game_on,
    input  attract,
    input  trg_time_n,
    input  time_left,
    input  tick,
    input  time_up
  );

  modport slave (
    input  coin_n,
    input  start_n,
    input  playtime,
    output credits,
    output game_on,
    output attract,
    output trg_time_n,
    output time_left,
    output tick,
    output time_up
  );
endinterface

// File: rtl/gamecntl_sequencer.sv
// Game-flow controller: credits, start, playtime load
// and once-per-second countdown for the playtime timer.
module gamecntl_sequencer #(
  parameter int DIV_BW      = 20,
  parameter int MAX_CREDITS = 9,
  parameter int END_HOLD    = 3
) (
  input  logic clk_drv,
  input  logic rst,
  gamecntl_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_ATTRACT,
    ST_LOAD,
    ST_PLAY,
    ST_OVER
  } state_t;

  localparam int HOLD_W = $clog2(END_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'(END_HOLD - 1);
  localparam logic [3:0] MAXC = 4'(MAX_CREDITS);
  localparam logic [DIV_BW-1:0] DIV_MAX = '1;

  state_t            state;
  logic [DIV_BW-1:0] div;
  logic [HOLD_W-1:0] hold;
  logic              coin_s;
  logic              coin_p;
  logic              start_s;
  logic              start_p;
  logic              coin_ev;
  logic              start_ev;
  logic              take;
  logic [7:0]        load_val;

  logic [3:0]        credits;
  logic              game_on;
  logic              attract;
  logic              trg_n;
  logic [7:0]        time_left;
  logic              tick;
  logic              time_up;

  assign coin_ev  = coin_p & ~coin_s;
  assign start_ev = start_p & ~start_s;
  assign take     = (state == ST_ATTRACT)
                  && start_ev
                  && (credits != 4'd0);

  // Playtime DIP decode: 45 s + 15 s per step, 120 s beyond 10.
  always_comb begin
    load_val = 8'd120;
    if (bus.playtime <= 4'd10)
      load_val = 8'd45 + 8'd15 * {4'd0, bus.playtime};
  end

  // Sample and previous-sample registers for falling-edge detect.
  always_ff @(posedge clk_drv) begin
    if (rst) begin
      coin_s  <= 1'b1;
      coin_p  <= 1'b1;
      start_s <= 1'b1;
      start_p <= 1'b1;
    end else begin
      coin_s  <= bus.coin_n;
      coin_p  <= coin_s;
      start_s <= bus.start_n;
      start_p <= start_s;
    end
  end

  // Free-running 1 s divider, zeroed on entry to LOAD so the
  // first second of play is a full period.
  always_ff @(posedge clk_drv) begin
    if (rst) begin
      div  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (div == DIV_MAX);
      div  <= take ? '0 : div + 1'b1;
    end
  end

  // Credit counter: a coin and an accepted start cancel out.
  always_ff @(posedge clk_drv) begin
    if (rst) begin
      credits <= 4'd0;
    end else if (coin_ev && !take) begin
      if (credits != MAXC)
        credits <= credits + 4'd1;
    end else if (take && !coin_ev) begin
      credits <= credits - 4'd1;
    end
  end

  // Game FSM; LOAD-cycle outputs are registered on entry
  // so they are visible during the LOAD cycle itself.
  always_ff @(posedge clk_drv) begin
    if (rst) begin
      state     <= ST_ATTRACT;
      time_left <= 8'd0;
      hold      <= '0;
      trg_n     <= 1'b1;
      game_on   <= 1'b0;
      attract   <= 1'b1;
      time_up   <= 1'b0;
    end else begin
      trg_n   <= 1'b1;
      time_up <= 1'b0;
      unique case (state)
        ST_ATTRACT: begin
          if (take) begin
            state     <= ST_LOAD;
            time_left <= load_val;
            trg_n     <= 1'b0;
            game_on   <= 1'b1;
            attract   <= 1'b0;
          end
        end
        ST_LOAD: begin
          state <= ST_PLAY;
        end
        ST_PLAY: begin
          if (tick) begin
            if (time_left == 8'd1) begin
              time_left <= 8'd0;
              time_up   <= 1'b1;
              hold      <= '0;
              game_on   <= 1'b0;
              state     <= ST_OVER;
            end else if (time_left != 8'd0) begin
              time_left <= time_left - 8'd1;
            end
          end
        end
        ST_OVER: begin
          if (tick) begin
            if (hold == HOLD_LAST) begin
              state   <= ST_ATTRACT;
              attract <= 1'b1;
            end else begin
              hold <= hold + 1'b1;
            end
          end
        end
        default: state <= ST_ATTRACT;
      endcase
    end
  end

  assign bus.credits    = credits;
  assign bus.game_on    = game_on;
  assign bus.attract    = attract;
  assign bus.trg_time_n = trg_n;
  assign bus.time_left  = time_left;
  assign bus.tick       = tick;
  assign bus.time_up    = time_up;

endmodule
